// File: rtl/rsa_pkg.sv
// Shared constants for the RSA host command responder: widths, opcodes, state encoding.
package rsa_pkg;

  localparam int unsigned DATA_W  = 1024;
  localparam int unsigned CMD_W   = 32;
  localparam int unsigned STATE_W = 3;

  // Host command opcodes; every other value is illegal
  localparam logic [CMD_W-1:0] CMD_READ    = CMD_W'(0);
  localparam logic [CMD_W-1:0] CMD_COMPUTE = CMD_W'(1);
  localparam logic [CMD_W-1:0] CMD_WRITE   = CMD_W'(2);

  // State encoding, visible on leds[2:0]
  localparam logic [STATE_W-1:0] ST_IDLE       = 3'd0;
  localparam logic [STATE_W-1:0] ST_CMD_ACK    = 3'd1;
  localparam logic [STATE_W-1:0] ST_READ       = 3'd2;
  localparam logic [STATE_W-1:0] ST_COMPUTE    = 3'd3;
  localparam logic [STATE_W-1:0] ST_WRITE      = 3'd4;
  localparam logic [STATE_W-1:0] ST_DONE       = 3'd5;
  localparam logic [STATE_W-1:0] ST_P2_RELEASE = 3'd6;

endpackage

// File: rtl/rsa_cmd_responder.sv
// Device-side command responder: host handshake on port1/port2, one-entry BRAM
// operand buffer, modexp core launch and result write-back.
module rsa_cmd_responder
  import rsa_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [CMD_W-1:0]  port1_din,
  input  logic              port1_valid,
  output logic              port1_read,
  output logic              port2_valid,
  input  logic              port2_read,
  input  logic [DATA_W-1:0] bram_din,
  input  logic              bram_din_valid,
  output logic [DATA_W-1:0] bram_dout,
  output logic              bram_dout_valid,
  input  logic              bram_dout_read,
  output logic [DATA_W-1:0] core_din,
  output logic              core_start,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_dout,
  output logic [3:0]        leds
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [CMD_W-1:0]   cmd_q, cmd_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [DATA_W-1:0]  rx_buf_q, rx_buf_d;
  logic               rx_full_q, rx_full_d;
  logic               err_q, err_d;
  logic               port1_read_q, port1_read_d;
  logic               port2_valid_q, port2_valid_d;
  logic [DATA_W-1:0]  bram_dout_q, bram_dout_d;
  logic               bram_dout_valid_q, bram_dout_valid_d;
  logic               core_start_q, core_start_d;
  logic               rx_consume;

  // Next-state, registered-output and rx-buffer logic
  always_comb begin
    state_d           = state_q;
    cmd_d             = cmd_q;
    data_d            = data_q;
    rx_buf_d          = rx_buf_q;
    rx_full_d         = rx_full_q;
    err_d             = err_q;
    port1_read_d      = port1_read_q;
    port2_valid_d     = port2_valid_q;
    bram_dout_d       = bram_dout_q;
    bram_dout_valid_d = bram_dout_valid_q;
    core_start_d      = 1'b0;
    rx_consume        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (port1_valid) begin
          cmd_d        = port1_din;
          port1_read_d = 1'b1;
          state_d      = ST_CMD_ACK;
        end
      end
      ST_CMD_ACK: begin
        if (!port1_valid) begin
          port1_read_d = 1'b0;
          case (cmd_q)
            CMD_READ: state_d = ST_READ;
            CMD_COMPUTE: begin
              core_start_d = 1'b1;
              state_d      = ST_COMPUTE;
            end
            CMD_WRITE: begin
              bram_dout_d       = data_q;
              bram_dout_valid_d = 1'b1;
              state_d           = ST_WRITE;
            end
            default: begin
              err_d         = 1'b1;
              port2_valid_d = 1'b1;
              state_d       = ST_DONE;
            end
          endcase
        end
      end
      ST_READ: begin
        if (rx_full_q) begin
          data_d        = rx_buf_q;
          rx_consume    = 1'b1;
          port2_valid_d = 1'b1;
          state_d       = ST_DONE;
        end
      end
      ST_COMPUTE: begin
        // A done coinciding with our own start pulse belongs to nothing we launched
        if (core_done && !core_start_q) begin
          data_d        = core_dout;
          port2_valid_d = 1'b1;
          state_d       = ST_DONE;
        end
      end
      ST_WRITE: begin
        if (bram_dout_read) begin
          bram_dout_valid_d = 1'b0;
          port2_valid_d     = 1'b1;
          state_d           = ST_DONE;
        end
      end
      ST_DONE: begin
        if (port2_read) begin
          port2_valid_d = 1'b0;
          state_d       = ST_P2_RELEASE;
        end
      end
      ST_P2_RELEASE: begin
        if (!port2_read) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Strobe is accepted in every state; only an unconsumed overwrite is an error
    if (bram_din_valid) begin
      rx_buf_d  = bram_din;
      rx_full_d = 1'b1;
      if (rx_full_q && !rx_consume) err_d = 1'b1;
    end else if (rx_consume) begin
      rx_full_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= ST_IDLE;
      cmd_q             <= '0;
      data_q            <= '0;
      rx_buf_q          <= '0;
      rx_full_q         <= 1'b0;
      err_q             <= 1'b0;
      port1_read_q      <= 1'b0;
      port2_valid_q     <= 1'b0;
      bram_dout_q       <= '0;
      bram_dout_valid_q <= 1'b0;
      core_start_q      <= 1'b0;
    end else begin
      state_q           <= state_d;
      cmd_q             <= cmd_d;
      data_q            <= data_d;
      rx_buf_q          <= rx_buf_d;
      rx_full_q         <= rx_full_d;
      err_q             <= err_d;
      port1_read_q      <= port1_read_d;
      port2_valid_q     <= port2_valid_d;
      bram_dout_q       <= bram_dout_d;
      bram_dout_valid_q <= bram_dout_valid_d;
      core_start_q      <= core_start_d;
    end
  end

  assign port1_read      = port1_read_q;
  assign port2_valid     = port2_valid_q;
  assign bram_dout       = bram_dout_q;
  assign bram_dout_valid = bram_dout_valid_q;
  assign core_start      = core_start_q;
  assign core_din        = data_q;
  assign leds            = {err_q, state_q};

endmodule

// File: tb/tb_rsa_cmd_responder.sv
// Randomized bench for rsa_cmd_responder against a transaction-level model.
module tb_rsa_cmd_responder;
  import rsa_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic [CMD_W-1:0]  port1_din;
  logic              port1_valid, port1_read, port2_valid, port2_read;
  logic [DATA_W-1:0] bram_din, bram_dout, core_din, core_dout;
  logic              bram_din_valid, bram_dout_valid, bram_dout_read;
  logic              core_start, core_done;
  logic [3:0]        leds;

  int n_checks = 0;
  int n_pass   = 0;
  int n_starts = 0;
  int n_rises  = 0;

  // Model state: what the device must hold, tracked per transaction
  logic [DATA_W-1:0] mdl_data = '0;
  logic [DATA_W-1:0] mdl_rx   = '0;
  bit                mdl_rx_full = 1'b0;
  bit                mdl_err     = 1'b0;
  logic [DATA_W-1:0] last_dout   = '0;

  logic [DATA_W-1:0] core_val = '0;
  int                core_lat = 4;
  bit                stub_busy = 1'b0;

  always #5 clk = ~clk;

  rsa_cmd_responder dut (
    .clk(clk), .reset(reset),
    .port1_din(port1_din), .port1_valid(port1_valid), .port1_read(port1_read),
    .port2_valid(port2_valid), .port2_read(port2_read),
    .bram_din(bram_din), .bram_din_valid(bram_din_valid),
    .bram_dout(bram_dout), .bram_dout_valid(bram_dout_valid), .bram_dout_read(bram_dout_read),
    .core_din(core_din), .core_start(core_start), .core_done(core_done), .core_dout(core_dout),
    .leds(leds)
  );

  function automatic logic [DATA_W-1:0] rnd_wide();
    logic [DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < int'(DATA_W / 32); i++) v = (v << 32) | DATA_W'($urandom);
    return v;
  endfunction

  function automatic logic [255:0] fold(input logic [DATA_W-1:0] v);
    logic [255:0] f;
    f = '0;
    for (int i = 0; i < int'(DATA_W / 256); i++) f ^= v[i*256 +: 256];
    return f;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic chkw(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got(folded) %h expected(folded) %h (t=%0t)", nm, fold(act), fold(exp), $time);
  endtask

  task automatic outs_zero();
    chk("rst_ctrl", 64'({port1_read, port2_valid, bram_dout_valid, core_start}), 64'(0));
    chk("rst_leds", 64'(leds), 64'(0));
    chkw("rst_dout", bram_dout, '0);
    chkw("rst_core_din", core_din, '0);
  endtask

  task automatic model_reset();
    mdl_data = '0; mdl_rx = '0; mdl_rx_full = 1'b0; mdl_err = 1'b0;
  endtask

  // One-cycle BRAM strobe, folded into the model buffer
  task automatic strobe(input logic [DATA_W-1:0] v);
    @(posedge clk); #1;
    bram_din = v; bram_din_valid = 1'b1;
    @(posedge clk); #1;
    bram_din_valid = 1'b0; bram_din = rnd_wide();
    if (mdl_rx_full) mdl_err = 1'b1;
    mdl_rx = v; mdl_rx_full = 1'b1;
  endtask

  // Full host transaction: issue, serve bram_dout, wait completion, acknowledge
  task automatic do_cmd(input logic [CMD_W-1:0] cmd, input bit early,
                        input logic [DATA_W-1:0] early_v, input logic [DATA_W-1:0] late_v);
    int s0, d0, k;
    bit ok, done_seen, got;
    logic [DATA_W-1:0] seen;
    s0 = n_starts; d0 = n_rises; ok = 1'b0; done_seen = 1'b0; got = 1'b0; seen = '0;
    @(posedge clk); #1;
    port1_din = cmd; port1_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = port1_read; end
    chk("p1_read_seen", 64'(ok), 64'(1));
    if (early && ok) strobe(early_v);
    k = int'($urandom_range(0, 2));
    repeat (k) @(posedge clk);
    @(posedge clk); #1;
    port1_valid = 1'b0; port1_din = $urandom;
    if (!ok) return;
    case (cmd)
      CMD_READ: begin
        if (!mdl_rx_full) begin repeat (2) @(posedge clk); strobe(late_v); end
        mdl_data = mdl_rx; mdl_rx_full = 1'b0;
      end
      CMD_COMPUTE: mdl_data = core_val;
      CMD_WRITE: ;
      default: mdl_err = 1'b1;
    endcase
    for (int i = 0; i < 400 && !done_seen; i++) begin
      @(negedge clk);
      if (port2_valid) done_seen = 1'b1;
      else if (bram_dout_valid && !got) begin
        got = 1'b1; seen = bram_dout;
        k = int'($urandom_range(0, 3));
        repeat (k) @(posedge clk);
        @(posedge clk); #1 bram_dout_read = 1'b1;
        @(posedge clk); #1 bram_dout_read = 1'b0;
      end
    end
    chk("p2_valid_seen", 64'(done_seen), 64'(1));
    if (!done_seen) return;
    chk("err_sticky", 64'(leds[3]), 64'(mdl_err));
    chk("core_starts", 64'(n_starts - s0), 64'(cmd == CMD_COMPUTE));
    chk("dout_rises", 64'(n_rises - d0), 64'(cmd == CMD_WRITE));
    chkw("data_reg", core_din, mdl_data);
    chk("done_state", 64'(leds[2:0]), 64'(5));
    if (got) begin last_dout = seen; chkw("bram_dout", seen, mdl_data); end
    k = int'($urandom_range(1, 3));
    @(posedge clk); #1 port2_read = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("p2_drop", 64'(port2_valid), 64'(0));
    chk("release_state", 64'(leds[2:0]), 64'(6));
    repeat (k - 1) @(posedge clk);
    @(posedge clk); #1 port2_read = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("idle_state", 64'(leds[2:0]), 64'(0));
  endtask

  // Core stub: spurious done during the start cycle, real result core_lat cycles later
  initial begin
    core_done = 1'b0; core_dout = '0;
    forever begin
      @(negedge clk);
      if (core_start && !reset) begin
        stub_busy = 1'b1;
        core_done = 1'b1; core_dout = ~core_val;
        @(posedge clk); #1 core_done = 1'b0;
        repeat (core_lat - 1) @(posedge clk);
        #1 core_done = 1'b1; core_dout = core_val;
        @(posedge clk); #1 core_done = 1'b0;
        stub_busy = 1'b0;
      end
    end
  end

  // Per-cycle protocol monitor
  logic prev_cs = 1'b0, prev_bdv = 1'b0, prev_bdr = 1'b0, prev_err = 1'b0;
  logic prev_p1r = 1'b0, prev_p1v = 1'b0, prev_rst = 1'b1;
  logic [DATA_W-1:0] prev_bdo = '0;
  always @(negedge clk) begin
    if (reset) begin
      outs_zero();
    end else if (!prev_rst) begin
      if (prev_cs) chk("start_width", 64'(core_start), 64'(0));
      if (prev_bdv && !prev_bdr) begin
        chk("dout_valid_hold", 64'(bram_dout_valid), 64'(1));
        chkw("dout_stable", bram_dout, prev_bdo);
      end
      if (prev_bdv && prev_bdr) chk("dout_valid_drop", 64'(bram_dout_valid), 64'(0));
      if (!bram_dout_valid) chkw("dout_idle_hold", bram_dout, prev_bdo);
      if (prev_err) chk("err_persist", 64'(leds[3]), 64'(1));
      if (prev_p1r && !prev_p1v) chk("p1_read_drop", 64'(port1_read), 64'(0));
      if (core_start) n_starts++;
      if (bram_dout_valid && !prev_bdv) n_rises++;
    end
    prev_cs = core_start; prev_bdv = bram_dout_valid; prev_bdr = bram_dout_read;
    prev_err = leds[3]; prev_p1r = port1_read; prev_p1v = port1_valid;
    prev_rst = reset; prev_bdo = bram_dout;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] v_a, v_b, v_c;
    bit ok;
    reset = 1'b0; port1_din = '0; port1_valid = 1'b0; port2_read = 1'b0;
    bram_din = '0; bram_din_valid = 1'b0; bram_dout_read = 1'b0;
    #2 reset = 1'b1;
    #1 outs_zero();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // READ then WRITE of the reference pattern
    v_a = DATA_W'(64'h0123456789abcdef) << 512;
    do_cmd(CMD_READ, 1'b0, '0, v_a);
    chk("read_pin", core_din[575:512], 64'h0123456789abcdef);
    do_cmd(CMD_WRITE, 1'b0, '0, '0);
    chkw("write_pin", last_dout, DATA_W'(64'h0123456789abcdef) << 512);

    // COMPUTE with a 20-cycle core
    core_val = DATA_W'(5); core_lat = 20;
    do_cmd(CMD_COMPUTE, 1'b0, '0, '0);
    do_cmd(CMD_WRITE, 1'b0, '0, '0);
    chkw("compute_pin", last_dout, DATA_W'(5));

    // Strobe during CMD_ACK
    v_b = rnd_wide();
    do_cmd(CMD_READ, 1'b1, v_b, '0);
    chk("early_no_err", 64'(leds[3]), 64'(0));
    do_cmd(CMD_WRITE, 1'b0, '0, '0);
    chkw("early_pin", last_dout, v_b);

    // Reset while waiting on the core
    core_val = rnd_wide(); core_lat = 30;
    @(posedge clk); #1 port1_din = CMD_COMPUTE; port1_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = port1_read; end
    chk("rst_test_ack", 64'(ok), 64'(1));
    @(posedge clk); #1 port1_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 chk("in_compute", 64'(leds[2:0]), 64'(3));
    #1 reset = 1'b1;
    #1 outs_zero();
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 100 && stub_busy; i++) @(posedge clk);
    chk("stub_idle", 64'(stub_busy), 64'(0));
    do_cmd(CMD_READ, 1'b0, '0, rnd_wide());

    // Two strobes without a READ: second value wins, error flagged
    v_b = rnd_wide(); v_c = rnd_wide();
    strobe(v_b); strobe(v_c);
    do_cmd(CMD_READ, 1'b0, '0, '0);
    chk("double_err", 64'(leds[3]), 64'(1));
    do_cmd(CMD_WRITE, 1'b0, '0, '0);
    chkw("double_pin", last_dout, v_c);

    // Illegal command, then legal ones keep the sticky error
    do_cmd(32'h7, 1'b0, '0, '0);
    chk("illegal_err", 64'(leds[3]), 64'(1));
    core_val = rnd_wide(); core_lat = 3;
    do_cmd(CMD_COMPUTE, 1'b0, '0, '0);
    chk("illegal_persist", 64'(leds[3]), 64'(1));

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      int unsigned r;
      r = $urandom_range(0, 7);
      case (r)
        0, 1: do_cmd(CMD_READ, 1'($urandom_range(0, 1)), rnd_wide(), rnd_wide());
        2, 3: begin
          core_val = rnd_wide(); core_lat = int'($urandom_range(2, 10));
          do_cmd(CMD_COMPUTE, 1'b0, '0, '0);
        end
        4, 5: do_cmd(CMD_WRITE, 1'b0, '0, '0);
        6: do_cmd(CMD_W'($urandom_range(3, 1000)), 1'b0, '0, '0);
        default: strobe(rnd_wide());
      endcase
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
